// File: rtl/aibio_cdr_phdet_filter.sv
// Multi-lane CDR phase detector with majority vote and windowed vote filter.
// Lanes are synchronised into the PI clock domain, voted, integrated over a
// window of WIN_CYCLES votes, and turned into one-cycle up/dn corrections.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_FLUSH | 3 cycles after reset; pipeline fills, votes ignored, acc = 0
//  ST_RUN   | integrating votes, window counter advancing
//  ST_HOLD  | integration frozen while i_hold is high
module aibio_cdr_phdet_filter #(
    parameter int NUM_LANES  = 4,
    parameter int ACC_WIDTH  = 6,
    parameter int WIN_CYCLES = 16,
    parameter int THRESH     = 8
) (
    input  logic                 i_piclk,
    input  logic                 i_reset,
    input  logic [NUM_LANES-1:0] i_cdr_clk,
    input  logic [NUM_LANES-1:0] i_lane_en,
    input  logic                 i_sdr_mode,
    input  logic                 i_hold,
    output logic                 o_cdr_phdet,
    output logic                 o_up,
    output logic                 o_dn,
    output logic                 o_dec_valid,
    output logic [ACC_WIDTH-1:0] o_acc
);

    localparam int CNT_W = $clog2(WIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [ACC_WIDTH:0] ONE_W     = (ACC_WIDTH+1)'(1);
    localparam logic signed [ACC_WIDTH:0] ACC_MAX_W = (ACC_WIDTH+1)'(2**(ACC_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] ACC_MIN_W = (ACC_WIDTH+1)'(-(2**(ACC_WIDTH-1)));
    localparam logic signed [ACC_WIDTH:0] TH_W      = (ACC_WIDTH+1)'(THRESH);
    localparam logic signed [ACC_WIDTH:0] NTH_W     = (ACC_WIDTH+1)'(-THRESH);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [NUM_LANES-1:0]        sync1_q, sync2_q;
    logic                        vote_hi_q, vote_lo_q;
    logic                        vote_hi_d, vote_lo_d;
    logic [5:0]                  ones_c, n_c, ones_x2;

    state_t                      state_q;
    logic [1:0]                  flush_q;
    logic [CNT_W-1:0]            cnt_q;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH:0]   sum_w, acc_ext;
    logic                        clr_q;
    logic                        up_q, dn_q, dec_q;
    logic                        win_end, dec_up, dec_dn;

    // Count enabled lanes and enabled lanes currently sampled high.
    always_comb begin
        ones_c = '0;
        n_c    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_c    = n_c + 6'(i_lane_en[i]);
            ones_c = ones_c + 6'(sync2_q[i] & i_lane_en[i]);
        end
    end

    assign ones_x2   = ones_c << 1;
    // n == 0 gives ones == 0, so both compares fail and no vote is cast.
    assign vote_hi_d = i_sdr_mode ? (ones_x2 < n_c) : (ones_x2 > n_c);
    assign vote_lo_d = i_sdr_mode ? (ones_x2 > n_c) : (ones_x2 < n_c);

    // Two-stage lane synchroniser followed by the registered vote.
    always_ff @(posedge i_piclk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            vote_hi_q <= 1'b0;
            vote_lo_q <= 1'b0;
        end else begin
            sync1_q   <= i_cdr_clk;
            sync2_q   <= sync1_q;
            vote_hi_q <= vote_hi_d;
            vote_lo_q <= vote_lo_d;
        end
    end

    // Saturating accumulator update; the cycle after a decision only clears.
    always_comb begin
        sum_w = {acc_q[ACC_WIDTH-1], acc_q};
        if (vote_hi_q) begin
            sum_w = sum_w + ONE_W;
        end else if (vote_lo_q) begin
            sum_w = sum_w - ONE_W;
        end
        if (clr_q) begin
            acc_d = '0;
        end else if (sum_w > ACC_MAX_W) begin
            acc_d = ACC_MAX_W[ACC_WIDTH-1:0];
        end else if (sum_w < ACC_MIN_W) begin
            acc_d = ACC_MIN_W[ACC_WIDTH-1:0];
        end else begin
            acc_d = sum_w[ACC_WIDTH-1:0];
        end
        acc_ext = {acc_d[ACC_WIDTH-1], acc_d};
    end

    assign win_end = (cnt_q == CNT_LAST);
    assign dec_up  = (acc_ext >= TH_W);
    assign dec_dn  = (acc_ext <= NTH_W);

    // Sequencing FSM with window counter, accumulator and decision outputs.
    always_ff @(posedge i_piclk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_FLUSH;
            flush_q <= 2'd2;
            cnt_q   <= '0;
            acc_q   <= '0;
            clr_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
            dec_q <= 1'b0;
            case (state_q)
                ST_FLUSH: begin
                    if (flush_q == 2'd0) begin
                        state_q <= ST_RUN;
                    end else begin
                        flush_q <= flush_q - 2'd1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    // Hold acts on the cycle it is seen, so it beats a window end.
                    state_q <= i_hold ? ST_HOLD : ST_RUN;
                    if (!i_hold) begin
                        acc_q <= acc_d;
                        if (win_end) begin
                            cnt_q <= '0;
                            clr_q <= 1'b1;
                            dec_q <= 1'b1;
                            up_q  <= dec_up;
                            dn_q  <= dec_dn;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                            clr_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_FLUSH;
            endcase
        end
    end

    assign o_cdr_phdet = vote_hi_q;
    assign o_up        = up_q;
    assign o_dn        = dn_q;
    assign o_dec_valid = dec_q;
    assign o_acc       = acc_q;

endmodule

// File: tb/tb_aibio_cdr_phdet_filter.sv
// Bench for aibio_cdr_phdet_filter: cycle model + scoreboard on the default
// instance, vector table of lane patterns, and directed hold/reset sequences
// (the latter also on a small ACC_WIDTH=4 / WIN_CYCLES=7 instance).
module tb_aibio_cdr_phdet_filter;

    localparam int AW  = 6;
    localparam int WIN = 16;
    localparam int TH  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] lanes, en;
    logic       sdr, hold;

    logic       o_cdr_phdet, o_up, o_dn, o_dec_valid;
    logic [AW-1:0] o_acc;
    logic       s_ph, s_up, s_dn, s_dec;
    logic [3:0] s_acc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aibio_cdr_phdet_filter u_dut (
        .i_piclk(clk), .i_reset(rst), .i_cdr_clk(lanes), .i_lane_en(en),
        .i_sdr_mode(sdr), .i_hold(hold), .o_cdr_phdet(o_cdr_phdet), .o_up(o_up),
        .o_dn(o_dn), .o_dec_valid(o_dec_valid), .o_acc(o_acc)
    );

    aibio_cdr_phdet_filter #(.NUM_LANES(4), .ACC_WIDTH(4), .WIN_CYCLES(7), .THRESH(4)) u_sat (
        .i_piclk(clk), .i_reset(rst), .i_cdr_clk(lanes), .i_lane_en(en),
        .i_sdr_mode(sdr), .i_hold(hold), .o_cdr_phdet(s_ph), .o_up(s_up),
        .o_dn(s_dn), .o_dec_valid(s_dec), .o_acc(s_acc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic          ph, up, dn, dec;
        logic [AW-1:0] acc;
    } exp_t;
    exp_t sbq[$];

    logic [3:0] mh1 = '0, mh2 = '0;
    bit  mph = 0, mlo = 0, mclr = 0;
    int  mflush = 0, mcnt = 0, macc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mh1 = '0; mh2 = '0; mph = 0; mlo = 0; mclr = 0;
            mflush = 0; mcnt = 0; macc = 0;
            sbq.delete();
        end else begin
            exp_t e;
            int   ones, n;
            bit   hi, lo;
            e.up = 0; e.dn = 0; e.dec = 0;
            if (mflush < 3) begin
                mflush++;
            end else if (!hold) begin
                if (mclr) begin
                    macc = 0;
                    mclr = 0;
                end else begin
                    if (mph) macc = macc + 1;
                    else if (mlo) macc = macc - 1;
                    if (macc > 2**(AW-1) - 1) macc = 2**(AW-1) - 1;
                    if (macc < -(2**(AW-1))) macc = -(2**(AW-1));
                end
                if (mcnt == WIN - 1) begin
                    e.dec = 1;
                    e.up  = (macc >= TH);
                    e.dn  = (macc <= -TH);
                    mcnt  = 0;
                    mclr  = 1;
                end else begin
                    mcnt++;
                end
            end
            ones = 0; n = 0;
            for (int i = 0; i < 4; i++) begin
                if (en[i]) begin
                    n++;
                    if (mh2[i]) ones++;
                end
            end
            hi = (2 * ones > n);
            lo = (2 * ones < n);
            mph = sdr ? lo : hi;
            mlo = sdr ? hi : lo;
            mh2 = mh1;
            mh1 = lanes;
            e.ph  = mph;
            e.acc = macc[AW-1:0];
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_phdet", o_cdr_phdet, e.ph);
            check("sb_up", o_up, e.up);
            check("sb_dn", o_dn, e.dn);
            check("sb_dec", o_dec_valid, e.dec);
            check("sb_acc", o_acc, e.acc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
    endtask

    task automatic wait_dec(input bit tog, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (tog) lanes = ~lanes;
        end while (!o_dec_valid && cyc < budget);
        if (!o_dec_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL dec_timeout: no o_dec_valid within %0d cycles, required a pulse", budget);
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] lanes;
        logic [3:0] en;
        bit         sdr;
        bit         tog;
        bit         up;
        bit         dn;
        logic [5:0] acc;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int cyc;
        vecs[0] = '{"all1",        4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 6'd16};
        vecs[1] = '{"all1_sdr",    4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 6'h30};
        vecs[2] = '{"tie",         4'h3, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[3] = '{"alternate",   4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
        vecs[4] = '{"lane0_only",  4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd16};
        vecs[5] = '{"three_of_4",  4'h7, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 6'd16};
        vecs[6] = '{"one_of_4_sdr",4'h1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 6'd16};
        vecs[7] = '{"none_enabled",4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
        vecs[8] = '{"lo_majority", 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 6'h30};

        lanes = 4'hF; en = 4'hF; sdr = 1'b0; hold = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_phdet", o_cdr_phdet, 0);
        check("reset_up", o_up, 0);
        check("reset_dn", o_dn, 0);
        check("reset_dec", o_dec_valid, 0);
        check("reset_acc", o_acc, 0);

        for (int v = 0; v < 9; v++) begin
            lanes = vecs[v].lanes; en = vecs[v].en; sdr = vecs[v].sdr;
            do_reset();
            wait_dec(vecs[v].tog, 40, cyc);
            check({vecs[v].name, "_first_dec_cycle"}, cyc, 19);
            check({vecs[v].name, "_up"}, o_up, vecs[v].up);
            check({vecs[v].name, "_dn"}, o_dn, vecs[v].dn);
            check({vecs[v].name, "_acc"}, o_acc, vecs[v].acc);
            wait_dec(vecs[v].tog, 40, cyc);
            check({vecs[v].name, "_dec_period"}, cyc, 16);
        end

        // Hold mid-window, then hold on the window-end cycle.
        lanes = 4'h1; en = 4'h1; sdr = 1'b0;
        do_reset();
        wait_dec(1'b0, 40, cyc);
        repeat (5) @(negedge clk);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_acc_frozen", o_acc, 4);
            check("hold_no_pulse", {o_up, o_dn, o_dec_valid}, 0);
        end
        hold = 1'b0;
        wait_dec(1'b0, 40, cyc);
        check("hold_window_stretch", cyc, 11);
        check("hold_release_up", o_up, 1);
        check("hold_release_acc", o_acc, 15);
        repeat (15) @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        check("hold_at_end_dec", o_dec_valid, 0);
        check("hold_at_end_acc", o_acc, 14);
        hold = 1'b0;
        @(negedge clk);
        check("after_end_hold_dec", o_dec_valid, 1);
        check("after_end_hold_up", o_up, 1);
        check("after_end_hold_acc", o_acc, 15);

        // Small instance: window of 7, then reset mid-window.
        lanes = 4'hF; en = 4'hF; sdr = 1'b0;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 2) check("sat_ph_edge2", s_ph, 0);
            if (k == 3) begin
                check("sat_ph_edge3", s_ph, 1);
                check("sat_acc_flush", s_acc, 0);
            end
            if (k == 4) check("sat_acc_edge4", s_acc, 1);
            if (k == 10) begin
                check("sat_dec", s_dec, 1);
                check("sat_up", s_up, 1);
                check("sat_acc_max", s_acc, 7);
            end
            if (k == 11) check("sat_acc_clear", s_acc, 0);
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_sat_outs", {s_ph, s_up, s_dn, s_dec}, 0);
        check("midrst_sat_acc", s_acc, 0);
        check("midrst_dut_ph", o_cdr_phdet, 0);
        check("midrst_dut_acc", o_acc, 0);
        @(negedge clk); #2 rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("post_rst_flush_acc", s_acc, (k == 4) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
